// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared types and constants for the generic inter-stage pipeline registers.
// Bit indices name the control bundle fields used by every stage instance.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;

   localparam int PIPE_CNT_W = 16;

   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_CONDMOV  = 1;
   localparam int CTRL_MEMTOREG = 2;
   localparam int CTRL_ZEROFLAG = 3;

endpackage

// File: rtl/pipe_stage_skid_reg_stall_counter.sv
// Saturating event counter; counts cycles where the stage output is stalled.
// Cleared only by reset, never wraps.
module pipe_stall_counter #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage register with valid/ready handshake, 2-entry skid and flush.
// Optional stall counter port enabled by PIPE_STALL_CNT_EN.
module pipe_stage_skid_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 4,
   parameter int DATA_W = 69
`ifdef PIPE_STALL_CNT_EN
  ,parameter int CNT_W  = PIPE_CNT_W
`endif
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,output logic [CNT_W-1:0]  stall_cnt
`endif
);

   pipe_state_t state, state_nxt;

   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic [DATA_W-1:0] main_data, skid_data;
   logic              in_ready_q;
   logic              in_fire, out_fire;
   logic              load_in, load_skid, skid_we;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_nxt = state;
      load_in   = 1'b0;
      load_skid = 1'b0;
      skid_we   = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_fire) begin
                  load_in   = 1'b1;
                  state_nxt = BUSY;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  load_in = 1'b1;
               end else if (in_fire) begin
                  skid_we   = 1'b1;
                  state_nxt = FULL;
               end else if (out_fire) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  load_skid = 1'b1;
                  state_nxt = BUSY;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_nxt;
         in_ready_q <= (state_nxt != FULL);
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         main_ctrl <= '0;
         main_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else begin
         if (load_in) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
         end else if (load_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
         end
         if (skid_we) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
         end
      end
   end

   // Bubbles must never carry RegWrite/MemtoReg into the next stage
   assign out_valid = (state != EMPTY);
   assign out_ctrl  = out_valid ? main_ctrl : '0;
   assign out_data  = main_data;
   assign in_ready  = in_ready_q;

`ifdef PIPE_STALL_CNT_EN
   pipe_stall_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .inc   (out_valid & ~out_ready),
      .cnt   (stall_cnt)
   );
`endif

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID … MEM/WB).
- Carries a generic control bundle and a generic data bundle between two pipeline stages.
- Adds a valid/ready handshake, a 2-entry skid buffer and synchronous flush.
- Control bits are forced to zero on bubbles, so a stalled or flushed stage can never assert RegWrite, MemtoReg and similar.

Parameters:
- CTRL_W, 4: width of the control bundle (RegWrite, CondMov, MemtoReg, ZeroFlag, …).
- DATA_W, 69: width of the data bundle (e.g. ALUResult 32 + DMResult 32 + WriteRegister 5).
- CNT_W, 16: stall-counter width; used only with the optional feature.

Ports:
- Clk  in  1  pipeline clock; all state changes on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; drops all held entries.
- in_valid  in  1  upstream stage presents a valid entry.
- in_ready  out  1  block can accept an entry; registered, depends only on state.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream stage accepts the entry this cycle.
- out_ctrl  out  CTRL_W  control bundle; all-zero whenever out_valid=0.
- out_data  out  DATA_W  data bundle; holds its last value when out_valid=0.
- stall_cnt  out  CNT_W  present only with PIPE_STALL_CNT_EN.

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - state=EMPTY, out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
  - Skid entry cleared; stall_cnt=0.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = (state != FULL).
  - Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N.
  - Sustained throughput is 1 entry/cycle with no combinational path from out_ready to in_ready.
- State machine. Registers: main (drives out_*) and skid.
  - EMPTY: in_fire → main<=in; go to BUSY.
  - BUSY, in_fire & out_fire → main<=in; stay BUSY.
  - BUSY, in_fire & !out_fire → skid<=in; go to FULL.
  - BUSY, !in_fire & out_fire → go to EMPTY.
  - BUSY, neither → hold.
  - FULL: out_fire → main<=skid; go to BUSY. in_ready=0, so no input is accepted.
  - FULL, !out_fire → hold.
- out_valid = (state != EMPTY).
- out_ctrl = out_valid ? main.ctrl : 0. This is a gated register output, not a combinational mux from inputs.
- Flush:
  - Highest priority. On the edge with flush=1, state→EMPTY and the skid is discarded.
  - An in_fire in the same cycle is dropped; upstream sees it as consumed.
  - An out_fire in the same cycle still counts downstream.
  - out_data is left unchanged.
- Ordering: entries leave in acceptance order; none is duplicated or lost except by flush.
- Reset mid-transfer: all state is lost immediately (asynchronous); out_ctrl is zero within the reset assertion.
- No arithmetic on the data bundle; bits pass through unmodified.

Optional Feature:
- PIPE_STALL_CNT_EN defined:
  - Adds the stall_cnt port.
  - Increments on every cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W−1, with no wrap.
  - Cleared only by reset; flush does not clear it.
- Not defined: port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - State enum {EMPTY, BUSY, FULL} (2 bits).
  - Default CNT_W.
  - Named CTRL bit-index constants (CTRL_REGWRITE=0, CTRL_CONDMOV=1, CTRL_MEMTOREG=2, CTRL_ZEROFLAG=3), shared by all stage instances.
- Sub-module pipe_stall_counter (saturating counter), instantiated only under PIPE_STALL_CNT_EN.
- Skid and main registers stay inline.

Test Plan:
1. Reset, then stream in_data=1..8, in_ctrl=4'b0101, out_ready=1 → outputs 1..8 on consecutive cycles after 1-cycle latency, out_ctrl=4'b0101, in_ready held at 1.
2. Send entries A, B with out_ready=0 → state FULL, in_ready=0 on the cycle after B. Raise out_ready → A then B on consecutive cycles, in_ready returns to 1 one cycle after A leaves.
3. In FULL, assert flush together with in_valid=1 → next cycle out_valid=0, out_ctrl=0, in_ready=1. The dropped entry never appears; the following entry C emerges alone.
4. Assert Rst_n=0 mid-stream with out_ctrl=4'b1111 → out_ctrl=0 and out_valid=0 immediately, without waiting for a Clk edge.
5. Random in_valid/out_ready at 50% for 10k cycles → scoreboard shows in-order, lossless delivery, out_ctrl==0 whenever out_valid==0.
6. With PIPE_STALL_CNT_EN, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt saturates at 15; flush leaves it at 15; reset returns it to 0.
